// File: rtl/fibonacci_stream_pkg.sv
// Shared types and arithmetic for the Fibonacci stream generator.
//   state_t : run-control FSM states
//   fib_add : one recurrence step on operands up to FIB_MAX_W bits wide,
//             returning {carry, sum} with wrap or clamp behaviour
package fib_pkg;

  localparam int unsigned FIB_MAX_W = 64;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Operands must already be confined to the low w bits. The returned flag is
  // the true carry-out; with sat set it is also raised whenever the result is
  // clamped, which includes an all-ones operand being propagated.
  function automatic logic [FIB_MAX_W:0] fib_add(
    input logic [FIB_MAX_W-1:0] a,
    input logic [FIB_MAX_W-1:0] b,
    input int unsigned          w,
    input logic                 sat
  );
    logic [FIB_MAX_W:0]   full;
    logic [FIB_MAX_W-1:0] ones;
    logic [FIB_MAX_W-1:0] s;
    logic                 c;
    ones = ~({FIB_MAX_W{1'b1}} << w);
    full = {1'b0, a} + {1'b0, b};
    c    = |(full >> w);
    s    = full[FIB_MAX_W-1:0] & ones;
    if (sat && (c || a == ones || b == ones)) begin
      s = ones;
      c = 1'b1;
    end
    return {c, s};
  endfunction

endpackage

// File: rtl/fibonacci_stream_if.sv
// Output beat stream of the Fibonacci generator.
//   out_valid/out_ready : handshake
//   out_data            : LANES terms, lane i at [i*WIDTH +: WIDTH]
//   out_last            : final beat of a run
//   out_mask            : lane i carries a real term
interface fibonacci_stream_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 2
);
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   out_last;
  logic [LANES-1:0]       out_mask;

  modport master (output out_valid, out_data, out_last, out_mask, input out_ready);
  modport slave  (input out_valid, out_data, out_last, out_mask, output out_ready);
endinterface

// File: rtl/fibonacci_stream_lane_step.sv
// Combinational recurrence chain: from (a, b) produce terms t0..t(LANES+1)
// and a per-term overflow flag.
//   a, b       : current pair of terms (t0, t1)
//   a_of, b_of : overflow flags already attached to a and b
//   t          : t[i] = term i of the chain
//   t_of       : t_of[i] = term i wrapped/clamped
// WIDTH must be below fib_pkg::FIB_MAX_W.
module fib_lane_step
  import fib_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LANES    = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  input  logic                             a_of,
  input  logic                             b_of,
  output logic [LANES+1:0][WIDTH-1:0]      t,
  output logic [LANES+1:0]                 t_of
);

  assign t[0]    = a;
  assign t[1]    = b;
  assign t_of[0] = a_of;
  assign t_of[1] = b_of;

  for (genvar i = 2; i < LANES + 2; i++) begin : g_term
    logic [FIB_MAX_W:0] r;
    assign r       = fib_add(FIB_MAX_W'(t[i-1]), FIB_MAX_W'(t[i-2]), WIDTH, SATURATE);
    assign t[i]    = r[WIDTH-1:0];
    // Bits above WIDTH are always zero after masking; folding them in keeps
    // every result bit consumed.
    assign t_of[i] = r[FIB_MAX_W] | (|r[FIB_MAX_W-1:WIDTH]);
  end

endmodule

// File: rtl/fibonacci_stream.sv
// Multi-lane Fibonacci sequence source with programmable seeds and term count.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : start pulse, honoured only in IDLE with count != 0
//   seed0, seed1   : t0, t1 of the run
//   count          : number of terms to emit
//   strm           : beat stream (valid/ready, data, last, mask)
//   overflow       : sticky, some emitted term wrapped or clamped
//   busy           : run in progress
module fibonacci_stream
  import fib_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LANES    = 2,
  parameter int CNT_W    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   seed0,
  input  logic [WIDTH-1:0]   seed1,
  input  logic [CNT_W-1:0]   count,
  fibonacci_stream_if.master strm,
  output logic               overflow,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

  state_t state, state_nxt;

  // Pair feeding the next beat, with their overflow flags, and the number of
  // terms still to emit after the beat currently presented.
  logic [WIDTH-1:0] a, b;
  logic             a_of, b_of;
  logic [CNT_W-1:0] rem;

  logic                   valid_q, last_q;
  logic [LANES*WIDTH-1:0] data_q;
  logic [LANES-1:0]       mask_q;

  logic [LANES+1:0][WIDTH-1:0] t;
  logic [LANES+1:0]            t_of;

  logic             start_ok, accept, load;
  logic [WIDTH-1:0] src_a, src_b;
  logic             src_a_of, src_b_of;
  logic [CNT_W-1:0] rem_in, rem_nxt;
  logic             last_nxt, beat_of;
  logic [LANES-1:0] mask_nxt;

  assign start_ok = (state == IDLE) && start && (count != '0);
  assign accept   = valid_q && strm.out_ready;
  // The first beat is built straight from the seeds so it is visible the
  // cycle after start; later beats replace the accepted one on the same edge.
  assign load     = start_ok || ((state == RUN) && accept && !last_q);

  assign src_a    = (state == IDLE) ? seed0 : a;
  assign src_b    = (state == IDLE) ? seed1 : b;
  assign src_a_of = (state == IDLE) ? 1'b0  : a_of;
  assign src_b_of = (state == IDLE) ? 1'b0  : b_of;
  assign rem_in   = (state == IDLE) ? count : rem;

  fib_lane_step #(
    .WIDTH    (WIDTH),
    .LANES    (LANES),
    .SATURATE (SATURATE)
  ) u_step (
    .a    (src_a),
    .b    (src_b),
    .a_of (src_a_of),
    .b_of (src_b_of),
    .t    (t),
    .t_of (t_of)
  );

  always_comb begin
    last_nxt = (rem_in <= LANES_C);
    rem_nxt  = last_nxt ? '0 : rem_in - LANES_C;
    mask_nxt = '0;
    for (int i = 0; i < LANES; i++) mask_nxt[i] = (rem_in > CNT_W'(i));
    // Only lanes that actually carry a term can raise overflow.
    beat_of  = |(t_of[LANES-1:0] & mask_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (accept && last_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      mask_q   <= '0;
      a        <= '0;
      b        <= '0;
      a_of     <= 1'b0;
      b_of     <= 1'b0;
      rem      <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      valid_q  <= 1'b1;
      last_q   <= last_nxt;
      data_q   <= t[LANES-1:0];
      mask_q   <= mask_nxt;
      a        <= t[LANES];
      b        <= t[LANES+1];
      a_of     <= t_of[LANES];
      b_of     <= t_of[LANES+1];
      rem      <= rem_nxt;
      overflow <= start_ok ? beat_of : (overflow | beat_of);
    end else if (accept) begin
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end
  end

  assign strm.out_valid = valid_q;
  assign strm.out_last  = last_q;
  assign strm.out_data  = data_q;
  assign strm.out_mask  = mask_q;
  assign busy           = (state == RUN);

endmodule

// File: tb/tb_fibonacci_stream.sv
module tb_fibonacci_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed0 = '0, seed1 = '0, count = '0;
  logic        ready = 1'b1;
  logic        ovf_w, ovf_s, busy_w, busy_s;

  int n_chk = 0;
  int n_err = 0;

  // Seeds 1,1 reduced mod 2^16: t24 = 75025 -> 9489, t25 = 121393 -> 55857.
  int fibw [26] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610,
                    987, 1597, 2584, 4181, 6765, 10946, 17711, 28657, 46368,
                    9489, 55857};

  always #5 clk = ~clk;

  fibonacci_stream_if #(.WIDTH(16), .LANES(2)) if_w ();
  fibonacci_stream_if #(.WIDTH(16), .LANES(2)) if_s ();
  assign if_w.out_ready = ready;
  assign if_s.out_ready = ready;

  fibonacci_stream #(.WIDTH(16), .LANES(2), .CNT_W(16), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
    .count(count), .strm(if_w), .overflow(ovf_w), .busy(busy_w));

  fibonacci_stream #(.WIDTH(16), .LANES(2), .CNT_W(16), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
    .count(count), .strm(if_s), .overflow(ovf_s), .busy(busy_s));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int s0, input int s1, input int n);
    seed0 = 16'(s0); seed1 = 16'(s1); count = 16'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input string tag, input int t0, input int t1, input logic [1:0] m,
                      input logic l);
    chk({tag, "_valid"}, if_w.out_valid, 1'b1);
    chk({tag, "_data"}, if_w.out_data, {16'(t1), 16'(t0)});
    chk({tag, "_mask"}, if_w.out_mask, m);
    chk({tag, "_last"}, if_w.out_last, l);
    chk({tag, "_busy"}, busy_w, 1'b1);
  endtask

  initial begin
    #2;
    chk("rst_valid", if_w.out_valid, 1'b0);
    chk("rst_last", if_w.out_last, 1'b0);
    chk("rst_data", if_w.out_data, 32'h0);
    chk("rst_mask", if_w.out_mask, 2'b00);
    chk("rst_busy", busy_w, 1'b0);
    chk("rst_ovf", ovf_w, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1) ten terms, five full beats
    go(1, 1, 10);
    beat("t1b1", 1, 1, 2'b11, 1'b0); tick();
    beat("t1b2", 2, 3, 2'b11, 1'b0); tick();
    beat("t1b3", 5, 8, 2'b11, 1'b0); tick();
    beat("t1b4", 13, 21, 2'b11, 1'b0); tick();
    beat("t1b5", 34, 55, 2'b11, 1'b1); tick();
    chk("t1_end_valid", if_w.out_valid, 1'b0);
    chk("t1_end_busy", busy_w, 1'b0);

    // 2) odd count, partial final beat
    go(1, 1, 5);
    beat("t2b1", 1, 1, 2'b11, 1'b0); tick();
    beat("t2b2", 2, 3, 2'b11, 1'b0); tick();
    chk("t2b3_lane0", if_w.out_data[15:0], 16'd5);
    chk("t2b3_mask", if_w.out_mask, 2'b01);
    chk("t2b3_last", if_w.out_last, 1'b1);
    tick();
    chk("t2_end_busy", busy_w, 1'b0);
    chk("t2_end_valid", if_w.out_valid, 1'b0);

    // 3) backpressure on beat 2
    go(1, 1, 10);
    beat("t3b1", 1, 1, 2'b11, 1'b0); tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("t3_hold", 2, 3, 2'b11, 1'b0);
    end
    ready = 1'b1;
    tick();
    beat("t3b3", 5, 8, 2'b11, 1'b0); tick();
    beat("t3b4", 13, 21, 2'b11, 1'b0); tick();
    beat("t3b5", 34, 55, 2'b11, 1'b1); tick();
    chk("t3_end_busy", busy_w, 1'b0);

    // 4) 26 terms, wrap vs saturate on beat 13
    go(1, 1, 26);
    for (int k = 0; k < 13; k++) begin
      chk("t4_data", if_w.out_data, {16'(fibw[2*k+1]), 16'(fibw[2*k])});
      chk("t4_ovf_w", ovf_w, k == 12);
      chk("t4_ovf_s", ovf_s, k == 12);
      chk("t4_last", if_w.out_last, k == 12);
      if (k == 11) chk("t4_sat_b12", if_s.out_data, {16'd46368, 16'd28657});
      if (k == 12) chk("t4_sat_b13", if_s.out_data, 32'hFFFF_FFFF);
      tick();
    end
    chk("t4_ovf_sticky", ovf_w, 1'b1);
    chk("t4_end_busy", busy_w, 1'b0);

    // 5) reset mid-run, then a fresh run
    go(1, 1, 10);
    chk("t5_ovf_cleared", ovf_w, 1'b0);
    tick(); tick();
    beat("t5b3", 5, 8, 2'b11, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", if_w.out_valid, 1'b0);
    chk("t5_rst_busy", busy_w, 1'b0);
    chk("t5_rst_data", if_w.out_data, 32'h0);
    #2;
    rst = 1'b0;
    tick();
    go(3, 4, 4);
    beat("t5n1", 3, 4, 2'b11, 1'b0); tick();
    beat("t5n2", 7, 11, 2'b11, 1'b1); tick();
    chk("t5_end_busy", busy_w, 1'b0);

    // 6) zero count ignored; start during a run ignored
    go(1, 1, 0);
    chk("t6_zero_busy", busy_w, 1'b0);
    chk("t6_zero_valid", if_w.out_valid, 1'b0);
    tick();
    chk("t6_zero_busy2", busy_w, 1'b0);
    go(1, 1, 4);
    beat("t6b1", 1, 1, 2'b11, 1'b0);
    seed0 = 16'd3; seed1 = 16'd4; count = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    beat("t6b2", 2, 3, 2'b11, 1'b1);
    tick();
    chk("t6_end_busy", busy_w, 1'b0);
    chk("t6_end_valid", if_w.out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
